// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core (port 0) has fixed priority,
// loader/DMA (port 1) is aged into a forced grant after MAX_WAIT denied cycles.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall0,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt_r;
  logic              rd_pend_r;
  logic              rd_owner_r;
  logic              force1_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              rvalid0_s;
  logic              rvalid1_s;

  // Grant decision; grants are held off entirely while reset is asserted
  always_comb begin
    force1_s = (wait_cnt_r == MAX_CNT);
    gnt0_s   = 1'b0;
    gnt1_s   = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      gnt1_s = req1 & (force1_s | ~req0);
      gnt0_s = req0 & ~gnt1_s;
    end
  end

  // Memory drive muxed from the granted port, zero when idle
  always_comb begin
    mem_en_s    = gnt0_s | gnt1_s;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (gnt1_s) begin
      mem_we_s    = we1;
      mem_addr_s  = addr1;
      mem_wdata_s = wdata1;
    end else if (gnt0_s) begin
      mem_we_s    = we0;
      mem_addr_s  = addr0;
      mem_wdata_s = wdata0;
    end else begin
      mem_we_s    = 1'b0;
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
    end
  end

  // Aging counter: counts denied port-1 cycles, saturating at MAX_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (req1 && !gnt1_s) begin
      if (wait_cnt_r != MAX_CNT) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end else begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Read return tag: remembers which port owns the data arriving next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= 1'b0;
    end else if (mem_en_s && !mem_we_s) begin
      rd_pend_r  <= 1'b1;
      rd_owner_r <= gnt1_s;
    end else begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= rd_owner_r;
    end
  end

  // Steer returning read data to its owner only
  always_comb begin
    rvalid0_s = rd_pend_r & ~rd_owner_r;
    rvalid1_s = rd_pend_r & rd_owner_r;
    rdata0    = {DATA_W{1'b0}};
    rdata1    = {DATA_W{1'b0}};
    if (rvalid0_s) begin
      rdata0 = mem_rdata;
    end else begin
      rdata0 = {DATA_W{1'b0}};
    end
    if (rvalid1_s) begin
      rdata1 = mem_rdata;
    end else begin
      rdata1 = {DATA_W{1'b0}};
    end
  end

  assign gnt0      = gnt0_s;
  assign gnt1      = gnt1_s;
  assign stall0    = req0 & ~gnt0_s;
  assign mem_en    = mem_en_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign rvalid0   = rvalid0_s;
  assign rvalid1   = rvalid1_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle behaviour plus
// hand-written sequences for aging, request drop and reset during a read.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, stall0, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int errors;
  int checks;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .stall0(stall0), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req0;  logic we0;  logic [31:0] addr0; logic [31:0] wdata0;
    logic        req1;  logic we1;  logic [31:0] addr1; logic [31:0] wdata1;
    logic [31:0] mrd;
    logic        g0;    logic g1;   logic st0;  logic men;  logic mwe;
    logic [31:0] maddr; logic [31:0] mwd;
    logic        rv0;   logic rv1;  logic [31:0] rd0;   logic [31:0] rd1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [31:0] mrd);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    mem_rdata = mrd;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".gnt0"}, {31'd0, gnt0}, 32'd0);
    chk({nm, ".gnt1"}, {31'd0, gnt1}, 32'd0);
    chk({nm, ".mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({nm, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({nm, ".mem_addr"}, mem_addr, 32'd0);
    chk({nm, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({nm, ".rvalid0"}, {31'd0, rvalid0}, 32'd0);
    chk({nm, ".rvalid1"}, {31'd0, rvalid1}, 32'd0);
    chk({nm, ".rdata0"}, rdata0, 32'd0);
    chk({nm, ".rdata1"}, rdata1, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    //          req0  we0   addr0         wdata0        req1  we1   addr1       wdata1        mem_rdata      g0    g1    st0   men   mwe   maddr         mwd           rv0   rv1   rd0           rd1
    vecs[0]  = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h40,     32'h12345678, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40,       32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'hAAAA5555,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h4,      32'h0,        32'h11111111,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4,        32'h0,        1'b1, 1'b0, 32'h11111111, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'h22222222,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        32'h22222222};
    vecs[7]  = '{1'b1, 1'b1, 32'h80,       32'hCAFEF00D, 1'b0, 1'b0, 32'h0,      32'h0,        32'h33333333,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80,       32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h100,      32'h0,        1'b1, 1'b1, 32'h200,    32'h55,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,      32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'h44444444,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h44444444, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h8,      32'h0,        32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'hC,        32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'h5,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC,        32'h0,        1'b0, 1'b1, 32'h0,        32'h5};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,      32'h0,        32'h6,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h6,        32'h0};

    // Reset state, with both ports requesting
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'h99, 1'b1, 1'b1, 32'h14, 32'h98, 32'h77);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset.wait_cnt", 32'(dut.wait_cnt_r), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
            vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1, vecs[i].mrd);
      @(negedge clk);
      chk($sformatf("v%0d.gnt0", i), {31'd0, gnt0}, {31'd0, vecs[i].g0});
      chk($sformatf("v%0d.gnt1", i), {31'd0, gnt1}, {31'd0, vecs[i].g1});
      chk($sformatf("v%0d.stall0", i), {31'd0, stall0}, {31'd0, vecs[i].st0});
      chk($sformatf("v%0d.mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].men});
      chk($sformatf("v%0d.mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mwe});
      chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].maddr);
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].mwd);
      chk($sformatf("v%0d.rvalid0", i), {31'd0, rvalid0}, {31'd0, vecs[i].rv0});
      chk($sformatf("v%0d.rvalid1", i), {31'd0, rvalid1}, {31'd0, vecs[i].rv1});
      chk($sformatf("v%0d.rdata0", i), rdata0, vecs[i].rd0);
      chk($sformatf("v%0d.rdata1", i), rdata1, vecs[i].rd1);
      @(posedge clk); #1;
    end

    // Steady contention: port 1 forced in on cycles 4 and 9
    drive(1'b1, 1'b1, 32'h300, 32'h1, 1'b1, 1'b1, 32'h400, 32'h2, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("cont%0d.wait_cnt", k), 32'(dut.wait_cnt_r), 32'(k % 5));
      chk($sformatf("cont%0d.gnt1", k), {31'd0, gnt1}, (k == 4 || k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d.gnt0", k), {31'd0, gnt0}, (k == 4 || k == 9) ? 32'd0 : 32'd1);
      chk($sformatf("cont%0d.stall0", k), {31'd0, stall0}, (k == 4 || k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d.mem_addr", k), mem_addr, (k == 4 || k == 9) ? 32'h400 : 32'h300);
      @(posedge clk); #1;
    end

    // Port 1 gives up after two denials, then re-requests and must age from zero
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("drop%0d.gnt1", k), {31'd0, gnt1}, 32'd0);
      chk($sformatf("drop%0d.wait_cnt", k), 32'(dut.wait_cnt_r), 32'(k));
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    @(negedge clk);
    chk("drop.idle.gnt0", {31'd0, gnt0}, 32'd1);
    chk("drop.idle.wait_cnt", 32'(dut.wait_cnt_r), 32'd2);
    @(posedge clk); #1;
    req1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rereq%0d.wait_cnt", k), 32'(dut.wait_cnt_r), 32'(k));
      chk($sformatf("rereq%0d.gnt1", k), {31'd0, gnt1}, (k == 4) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end

    // Reset asserted while a port-0 read is granted: the read is dropped
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77);
    @(negedge clk);
    chk("rstrd.gnt0", {31'd0, gnt0}, 32'd1);
    chk("rstrd.mem_addr", mem_addr, 32'h10);
    #1 rst = 1'b1;
    #1 chk_all_zero("rstrd.during");
    @(posedge clk); #1;
    chk_all_zero("rstrd.edge");
    req0 = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rstrd.after%0d.rvalid0", k), {31'd0, rvalid0}, 32'd0);
      chk($sformatf("rstrd.after%0d.rdata0", k), rdata0, 32'd0);
      chk($sformatf("rstrd.after%0d.rvalid1", k), {31'd0, rvalid1}, 32'd0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store path and port 1 is the loader/DMA path that fills or inspects memory.
- Port 0 has fixed priority. An aging counter guarantees that port 1 is served within MAX_WAIT cycles.
- Read data returns one cycle after grant, tagged to the requester that owned the access.
- Sits between the core's memory-access stage, the loader, and the data memory instance.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied cycles for port 1 before it is forced priority (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 granted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1  in  1  port 1 access request.
- we1  in  1  port 1 write enable.
- addr1  in  ADDR_W  port 1 address.
- wdata1  in  DATA_W  port 1 write data.
- gnt1  out  1  port 1 granted this cycle.
- rvalid1  out  1  port 1 read data valid.
- rdata1  out  DATA_W  port 1 read data.
- stall0  out  1  req0 & ~gnt0, drives the core stall.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.

Behaviour:
- Reset (asynchronous, active-high): wait_cnt=0, rd_pend=0, rd_owner=0, so rvalid0=rvalid1=0.
  - While rst is high, gnt0=gnt1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0.
  - A read in flight when reset asserts is dropped; no rvalid follows release.
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high. A granted access is complete on that clock edge. A requester may issue back-to-back requests.
- Grant logic (combinational from req0, req1, wait_cnt):
  - force1 = (wait_cnt == MAX_WAIT).
  - gnt1 = req1 & (force1 | ~req0).
  - gnt0 = req0 & ~gnt1.
  - At most one grant per cycle. No request means no grant.
- Memory drive (combinational):
  - mem_en = gnt0 | gnt1.
  - mem_we, mem_addr, mem_wdata are muxed from the granted port.
  - When idle, mem_we, mem_addr and mem_wdata are 0.
- Aging counter:
  - wait_cnt increments when req1 & ~gnt1, saturating at MAX_WAIT.
  - It clears to 0 when gnt1 or when ~req1.
  - Width is clog2(MAX_WAIT+1).
- Read return pipeline, latency 1:
  - On the edge of a granted read (mem_en & ~mem_we): rd_pend=1 and rd_owner=granted port. Otherwise rd_pend=0.
  - rvalid0 = rd_pend & (rd_owner==0); rvalid1 = rd_pend & (rd_owner==1).
  - rdataN = mem_rdata when rvalidN, else 0.
  - Writes produce no rvalid.
  - Back-to-back reads yield rvalid on consecutive cycles, and owner switches correctly cycle by cycle.
- Simultaneous req0 & req1 with wait_cnt<MAX_WAIT: port 0 wins.
- Forced cycle: port 1 wins and port 0 stalls exactly one cycle, then priority returns to port 0.
- Steady contention: port 1 is granted once every MAX_WAIT+1 cycles.
- No combinational path from mem_rdata to any grant or memory-drive output.

Test Plan:
- Reset mid-read: port 0 read granted at addr 0x10, assert rst before the next edge → rvalid0 stays 0 after release and all outputs are 0 during reset.
- Single read: req0=1, we0=0, addr0=0x20, memory returns 0xDEADBEEF → gnt0=1 in cycle 0, mem_en=1, mem_addr=0x20; rvalid0=1, rdata0=0xDEADBEEF in cycle 1; rvalid1=0.
- Single write: req1=1, we1=1, addr1=0x40, wdata1=0x12345678, req0=0 → gnt1=1, mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; no rvalid the next cycle.
- Contention aging, MAX_WAIT=4: req0 and req1 held high continuously → gnt0 on cycles 0-3; gnt1 on cycle 4 with stall0=1; gnt0 on cycles 5-8; gnt1 on cycle 9. wait_cnt sequence is 1,2,3,4,0,...
- Interleaved reads: port 0 reads 0x0 in cycle 0, port 1 reads 0x4 in cycle 1 (req0 dropped) → rvalid0 in cycle 1 with mem_rdata(0x0); rvalid1 in cycle 2 with mem_rdata(0x4); never both high together.
- Port 1 drops its request after 2 denied cycles, then re-requests → wait_cnt returns to 0 and counts from 1 again; no forced grant before 4 further denied cycles.
